// File: rtl/joy_db15_pkg.sv
// Shared constants and types for the DB15 (SNAC) joystick responder.
// Frame defaults, button bit positions and the per-player button word type.
package joy_db15_pkg;

    localparam int BITS_PER_PLAYER = 12;
    localparam int FRAME_BITS      = 2 * BITS_PER_PLAYER;
    localparam int SYNC_STAGES     = 2;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_FIRE_A = 4;
    localparam int JB_FIRE_B = 5;
    localparam int JB_FIRE_C = 6;
    localparam int JB_FIRE_D = 7;
    localparam int JB_FIRE_E = 8;
    localparam int JB_FIRE_F = 9;
    localparam int JB_START  = 10;
    localparam int JB_COIN   = 11;

    typedef logic [BITS_PER_PLAYER-1:0] joy_buttons_t;

endpackage

// File: rtl/joy_sync.sv
// Multi-flop synchronizer for an idle-high asynchronous line, with
// rise/fall pulses derived from the last stage and a delayed copy of it.
module joy_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Flops reset high so an idle line never produces an edge after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/joy_db15_resp.sv
// Device-side DB15 joystick responder: emulates the 74HC165 chain, loading
// both player words on a low load strobe and shifting them out active-low.
module joy_db15_resp
    import joy_db15_pkg::*;
#(
    parameter int BITS_PER_PLAYER = joy_db15_pkg::BITS_PER_PLAYER,
    parameter int FRAME_BITS      = joy_db15_pkg::FRAME_BITS,
    parameter int SYNC_STAGES     = joy_db15_pkg::SYNC_STAGES
) (
    input  logic                       i_clk_sys,
    input  logic                       i_reset,
    input  logic                       i_joy_clk,
    input  logic                       i_joy_load,
    input  logic [BITS_PER_PLAYER-1:0] i_p1_buttons,
    input  logic [BITS_PER_PLAYER-1:0] i_p2_buttons,
    output logic                       o_joy_data,
    output logic                       o_frame_done,
    output logic                       o_overrun,
    output logic [4:0]                 o_bit_cnt
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);

    logic                  w_clk_level;
    logic                  w_clk_rise;
    logic                  w_clk_fall;
    logic                  w_load_level;
    logic                  w_load_rise;
    logic                  w_load_fall;
    logic                  w_unused_edges;
    logic [FRAME_BITS-1:0] w_frame;

    logic [FRAME_BITS-1:0] r_sr;
    logic                  r_frame_done;
    logic                  r_overrun;
    logic [4:0]            r_bit_cnt;

    joy_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_async (i_joy_clk),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    joy_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_async (i_joy_load),
        .o_level (w_load_level),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    assign w_unused_edges = w_clk_level ^ w_clk_fall ^ w_load_rise ^ w_load_fall;

    // Buttons go out active-low; player 1 bit 0 is the first bit on the wire.
    assign w_frame = {~i_p2_buttons, ~i_p1_buttons};

    // Load level dominates any shift edge seen in the same cycle.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_sr         <= '1;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (!w_load_level) begin
                r_sr      <= w_frame;
                r_bit_cnt <= '0;
                r_overrun <= 1'b0;
            end else if (w_clk_rise) begin
                r_sr <= {1'b1, r_sr[FRAME_BITS-1:1]};
                if (r_bit_cnt == CNT_FULL) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                if (r_bit_cnt == CNT_LAST) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign o_joy_data   = r_sr[0];
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;
    assign o_bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_joy_db15_resp.sv
// Self-checking bench for joy_db15_resp: table of full frames plus
// hand-written sequences for overrun, held load, mid-frame changes and reset.
module tb_joy_db15_resp;

    logic        clk;
    logic        reset;
    logic        joyClk;
    logic        joyLoad;
    logic [11:0] p1Buttons;
    logic [11:0] p2Buttons;
    logic        joyData;
    logic        frameDone;
    logic        overrun;
    logic [4:0]  bitCnt;

    int total = 0;
    int bad = 0;
    int doneCount = 0;

    typedef struct {
        logic [11:0] p1;
        logic [11:0] p2;
        logic [23:0] expWord;
    } vec_t;

    vec_t vecs[5];

    joy_db15_resp dut (
        .i_clk_sys    (clk),
        .i_reset      (reset),
        .i_joy_clk    (joyClk),
        .i_joy_load   (joyLoad),
        .i_p1_buttons (p1Buttons),
        .i_p2_buttons (p2Buttons),
        .o_joy_data   (joyData),
        .o_frame_done (frameDone),
        .o_overrun    (overrun),
        .o_bit_cnt    (bitCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frameDone) doneCount++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Set buttons, hold load low 8 cycles, release and let the sync settle.
    task automatic applyStimulus(input logic [11:0] p1, input logic [11:0] p2);
        p1Buttons = p1;
        p2Buttons = p2;
        joyLoad = 1'b0;
        cycles(8);
        joyLoad = 1'b1;
        cycles(4);
    endtask

    task automatic pulseClk();
        joyClk = 1'b0;
        cycles(4);
        joyClk = 1'b1;
        cycles(4);
    endtask

    initial begin
        logic [23:0] got;
        logic [6:0]  p1Tail;
        int doneBefore;

        vecs[0] = '{12'h001, 12'h800, 24'h7FFFFE};
        vecs[1] = '{12'h000, 12'h000, 24'hFFFFFF};
        vecs[2] = '{12'hFFF, 12'hFFF, 24'h000000};
        vecs[3] = '{12'hA5A, 12'h3C3, 24'hC3C5A5};
        vecs[4] = '{12'h00F, 12'h0F0, 24'hF0FFF0};

        reset = 1'b1;
        joyClk = 1'b1;
        joyLoad = 1'b1;
        p1Buttons = '0;
        p2Buttons = '0;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        checkOutput("reset joy_data", 32'(joyData), 32'd1);
        checkOutput("reset bit_cnt", 32'(bitCnt), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        cycles(100);
        checkOutput("idle joy_data", 32'(joyData), 32'd1);
        checkOutput("idle bit_cnt", 32'(bitCnt), 32'd0);
        checkOutput("idle frame_done count", 32'(doneCount), 32'd0);

        for (int v = 0; v < 5; v++) begin
            doneBefore = doneCount;
            applyStimulus(vecs[v].p1, vecs[v].p2);
            got = '0;
            got[0] = joyData;
            for (int k = 1; k < 24; k++) begin
                pulseClk();
                got[k] = joyData;
            end
            pulseClk();
            checkOutput($sformatf("frame word v%0d", v), 32'(got), 32'(vecs[v].expWord));
            checkOutput($sformatf("frame bit_cnt v%0d", v), 32'(bitCnt), 32'd24);
            checkOutput($sformatf("frame_done pulses v%0d", v), 32'(doneCount - doneBefore), 32'd1);
            checkOutput($sformatf("exhausted joy_data v%0d", v), 32'(joyData), 32'd1);
            checkOutput($sformatf("frame overrun v%0d", v), 32'(overrun), 32'd0);
        end

        // Two extra shift edges past the end of a frame.
        doneBefore = doneCount;
        pulseClk();
        pulseClk();
        checkOutput("overrun flag", 32'(overrun), 32'd1);
        checkOutput("overrun joy_data", 32'(joyData), 32'd1);
        checkOutput("overrun bit_cnt", 32'(bitCnt), 32'd24);
        checkOutput("overrun no extra done", 32'(doneCount - doneBefore), 32'd0);
        applyStimulus(12'h000, 12'h000);
        checkOutput("load clears overrun", 32'(overrun), 32'd0);
        checkOutput("load clears bit_cnt", 32'(bitCnt), 32'd0);

        // Shift edges while load is held low are ignored.
        p1Buttons = 12'h001;
        p2Buttons = 12'h000;
        joyLoad = 1'b0;
        cycles(8);
        doneBefore = doneCount;
        for (int k = 0; k < 3; k++) pulseClk();
        checkOutput("held load joy_data", 32'(joyData), 32'd0);
        checkOutput("held load bit_cnt", 32'(bitCnt), 32'd0);
        joyLoad = 1'b1;
        cycles(4);
        pulseClk();
        checkOutput("after held load first shift", 32'(joyData), 32'd1);
        checkOutput("after held load bit_cnt", 32'(bitCnt), 32'd1);

        // Buttons changing mid-frame must not disturb the frame in flight.
        applyStimulus(12'h000, 12'h000);
        for (int k = 0; k < 5; k++) pulseClk();
        checkOutput("mid-frame bit_cnt", 32'(bitCnt), 32'd5);
        p1Buttons = 12'hFFF;
        p1Tail = '0;
        p1Tail[0] = joyData;
        for (int k = 1; k < 7; k++) begin
            pulseClk();
            p1Tail[k] = joyData;
        end
        checkOutput("mid-frame p1 tail", 32'(p1Tail), 32'h7F);

        // Reset mid-frame aborts the frame until the next load.
        applyStimulus(12'hFFF, 12'h000);
        for (int k = 0; k < 10; k++) pulseClk();
        checkOutput("pre-reset joy_data", 32'(joyData), 32'd0);
        checkOutput("pre-reset bit_cnt", 32'(bitCnt), 32'd10);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkOutput("post-reset joy_data", 32'(joyData), 32'd1);
        checkOutput("post-reset bit_cnt", 32'(bitCnt), 32'd0);
        got = '0;
        for (int k = 0; k < 3; k++) begin
            pulseClk();
            got[k] = joyData;
        end
        checkOutput("post-reset shifted ones", 32'(got), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joy_db15_resp.md
Name: joy_db15_resp

Overview:
- Device-side responder for the serial SNAC DB15 joystick link. It emulates the 74HC165 shift-register chain on the DB15 adapter board.
- Captures two 12-bit player button words on the host's load strobe. Shifts them out, active-low, one bit per host clock edge on the data line.
- Used in board-to-board links and as the bench partner for the host-side DB15 reader in every arcade core.

Parameters:
- BITS_PER_PLAYER, 12, button bits per player word.
- FRAME_BITS, 24, bits per frame (2*BITS_PER_PLAYER); shift register width.
- SYNC_STAGES, 2, synchronizer depth on joy_clk and joy_load inputs.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- joy_clk  in  1  host shift clock, asynchronous; rising edge shifts.
- joy_load  in  1  host load strobe, asynchronous, active-low parallel load.
- p1_buttons  in  12  player 1 buttons, active-high ([0]=right,[1]=left,[2]=down,[3]=up,[4..11]=fire/start/coin).
- p2_buttons  in  12  player 2 buttons, same mapping.
- joy_data  out  1  serial data to host, active-low buttons, idle high.
- frame_done  out  1  one-cycle pulse when bit FRAME_BITS-1 has been shifted past.
- overrun  out  1  sticky flag: more than FRAME_BITS shift edges since last load.
- bit_cnt  out  5  shift edges counted since last load, saturating at FRAME_BITS.

Behaviour:
- Interface: one clock (clk_sys); reset is synchronous and active-high. All state changes on rising clk_sys only.
- joy_clk and joy_load each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage to a one-flop delayed copy.
- Frame word: W[i] = ~p1_buttons[i] for i=0..11; W[12+i] = ~p2_buttons[i]. Bit W[0] is output first. joy_data = sr[0] (registered).
- Load: while synchronized joy_load is low, sr <= W every cycle (level-sensitive, as the 74HC165), bit_cnt <= 0, overrun <= 0.
- Shift: on a synchronized joy_clk rising edge with joy_load high:
  - sr <= {1'b1, sr[FRAME_BITS-1:1]} (serial-in tied high).
  - bit_cnt increments, saturating at FRAME_BITS.
- Load low dominates: a joy_clk edge detected in the same cycle is ignored.
- Latency: a pin edge at clk_sys edge k changes joy_data after edge k+SYNC_STAGES+1 (3 cycles at default).
- frame_done pulses for one cycle on the shift edge that takes bit_cnt from FRAME_BITS-1 to FRAME_BITS.
- A shift edge with bit_cnt already at FRAME_BITS sets overrun. joy_data stays 1 after the frame is exhausted.
- Host timing requirement: joy_clk high and low phases each at least SYNC_STAGES+1 clk_sys cycles. Shorter pulses may be missed; no recovery is required.
- Button inputs are sampled only during load. Changes during shifting do not affect the frame in flight.
- Reset values: sr all ones, joy_data 1, frame_done 0, overrun 0, bit_cnt 0, synchronizer flops 1 (idle-high lines). No edge is detected on the first cycle after reset.
- Reset mid-frame: the frame is aborted. The next bit appears only after a new load.

Decomposition:
- Package joy_db15_pkg holds:
  - the BITS_PER_PLAYER and FRAME_BITS defaults;
  - localparam bit indices (JB_RIGHT=0, JB_LEFT=1, JB_DOWN=2, JB_UP=3, JB_FIRE_A=4 … JB_COIN=11);
  - a typedef for the 12-bit button word.
- One sub-module, joy_sync: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instanced twice (joy_clk, joy_load).

Test Plan:
- Reset, then idle with lines held high for 100 cycles -> joy_data=1, bit_cnt=0, frame_done never asserted.
- p1=12'h001, p2=12'h800; pulse joy_load low 8 cycles, then 24 joy_clk pulses at 8-cycle period -> serial stream:
  - first bit 0;
  - bits 1..22 = 1;
  - bit 23 = 0;
  - frame_done one pulse after the 24th edge;
  - bit_cnt=24.
- Continue with 2 extra joy_clk pulses after the previous frame -> joy_data=1, overrun=1. Next load clears overrun and bit_cnt to 0.
- Hold joy_load low and toggle joy_clk -> sr unchanged from W, joy_data tracks ~p1[0], bit_cnt stays 0.
- Change p1 from 12'h000 to 12'hFFF after the 5th shift -> remaining 7 P1 bits still output 1 (old frame preserved).
- Assert reset after 10 shifts -> next cycle joy_data=1, bit_cnt=0. Further joy_clk edges without load output 1s.
